// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the BCD-to-binary converter.
package bcd_pkg;
    localparam int BCD_DIGITS = 3;
    localparam int BIN_W      = 10;
    localparam int ACC_W      = 11;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } bcd2bin_state_t;
endpackage

// File: rtl/bcd_to_bin_if.sv
// Handshake bundle for bcd_to_bin: packed BCD word in, binary result out.
interface bcd_to_bin_if;
    import bcd_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [4*BCD_DIGITS-1:0] in_bcd;
    logic                    out_valid;
    logic                    out_ready;
    logic [BIN_W-1:0]        out_bin;
    logic                    out_err;

    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_bin, out_err
    );

    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_bin, out_err
    );
endinterface

// File: rtl/bcd_mac10.sv
// Combinational decimal multiply-accumulate step: sum = acc*10 + digit, wrapping in ACC_W bits.
module bcd_mac10
    import bcd_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] sum
);
    assign sum = (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, digit};
endmodule

// File: rtl/bcd_to_bin.sv
// Digit-serial 3-digit packed BCD to binary converter, MSD first, valid/ready on both sides.
// Optional nibble range check enabled by defining BCD2BIN_ERR_EN.
module bcd_to_bin #(
    parameter int DIGITS = bcd_pkg::BCD_DIGITS,
    parameter int BIN_W  = bcd_pkg::BIN_W
) (
    input  logic         clk,
    input  logic         rst,
    bcd_to_bin_if.slave  bus
);
    import bcd_pkg::*;

    bcd2bin_state_t          state_q, state_d;
    logic [4*BCD_DIGITS-1:0] shreg_q, shreg_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [ACC_W-1:0]        mac_sum;
    logic [1:0]              cnt_q, cnt_d;

`ifdef BCD2BIN_ERR_EN
    logic err_q, err_d;

    function automatic logic has_bad_nibble(input logic [4*BCD_DIGITS-1:0] w);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (w[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction
`endif

    // The shift register presents the next digit at its top nibble.
    bcd_mac10 u_mac (
        .acc   (acc_q),
        .digit (shreg_q[4*BCD_DIGITS-1 -: 4]),
        .sum   (mac_sum)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`ifdef BCD2BIN_ERR_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    shreg_d = bus.in_bcd;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef BCD2BIN_ERR_EN
                    err_d   = has_bad_nibble(bus.in_bcd);
`endif
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d   = mac_sum;
                shreg_d = {shreg_q[4*BCD_DIGITS-5:0], 4'h0};
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == 2'(DIGITS - 1)) state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef BCD2BIN_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`ifdef BCD2BIN_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // Pure datapath: always written at capture before it is consumed.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
`ifdef BCD2BIN_ERR_EN
    assign bus.out_bin   = err_q ? '0 : acc_q[BIN_W-1:0];
    assign bus.out_err   = err_q;
`else
    assign bus.out_bin   = acc_q[BIN_W-1:0];
    assign bus.out_err   = 1'b0;
`endif
endmodule
